// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with a two-entry skid buffer.
// The head (main) entry drives the write-back outputs. The skid entry catches
// one extra item while downstream stalls, so the upstream stage sees a
// registered ready signal without losing data.
module mem_wb_skid #(
  parameter int DATA_W            = 32,
  parameter int RADDR_W           = 5,
  parameter int ZERO_REG_SUPPRESS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic [1:0]         WB_in,
  input  logic [DATA_W-1:0]  ReadData_in,
  input  logic [DATA_W-1:0]  ALU_in,
  input  logic [RADDR_W-1:0] instruction_mux_in,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               RegWrite,
  output logic               MemtoReg,
  output logic [DATA_W-1:0]  ReadData_out,
  output logic [DATA_W-1:0]  ALU_out,
  output logic [RADDR_W-1:0] instruction_mux_out,
  output logic [DATA_W-1:0]  WriteData,
  output logic [1:0]         occupancy
);

  // One held pipeline entry: write-back controls, load data, ALU result, destination.
  typedef struct packed {
    logic [1:0]         wb;
    logic [DATA_W-1:0]  rdata;
    logic [DATA_W-1:0]  alu;
    logic [RADDR_W-1:0] dest;
  } entry_t;

  localparam int ENTRY_W = 2 + 2 * DATA_W + RADDR_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [1:0]   r_occupancy;
  entry_t       r_main;
  entry_t       r_skid;
  entry_t       w_in_entry;

  logic         w_acc;
  logic         w_con;
  logic         w_in_ready_nxt;
  logic         w_out_valid_nxt;
  logic [1:0]   w_occupancy_nxt;
  logic         w_main_ld_in;
  logic         w_main_ld_skid;
  logic         w_skid_ld_in;
  logic         w_clear;
  logic         w_dest_ok;

  assign w_in_entry = {WB_in, ReadData_in, ALU_in, instruction_mux_in};

  // Handshake qualifiers are built from the registered status flags only.
  assign w_acc = in_valid & r_in_ready;
  assign w_con = r_out_valid & out_ready;

  // State register; ready/valid/occupancy are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occupancy <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_occupancy <= w_occupancy_nxt;
    end
  end

  // Next-state logic. Flush overrides every handshake outcome.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_state_nxt = ST_ONE;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_acc && !w_con) begin
          w_state_nxt = ST_TWO;
        end else if (!w_acc && w_con) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_ONE;
        end
      end
      ST_TWO: begin
        if (w_con) begin
          w_state_nxt = ST_ONE;
        end else begin
          w_state_nxt = ST_TWO;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // Output decode: status flags for the next cycle and entry-move enables.
  always_comb begin
    w_in_ready_nxt  = 1'b1;
    w_out_valid_nxt = 1'b0;
    w_occupancy_nxt = 2'd0;
    case (w_state_nxt)
      ST_EMPTY: begin
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
        w_occupancy_nxt = 2'd0;
      end
      ST_ONE: begin
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b1;
        w_occupancy_nxt = 2'd1;
      end
      ST_TWO: begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b1;
        w_occupancy_nxt = 2'd2;
      end
      default: begin
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
        w_occupancy_nxt = 2'd0;
      end
    endcase

    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld_in   = 1'b0;
    w_clear        = 1'b0;
    if (flush) begin
      w_clear = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_main_ld_in = 1'b1;
          end else begin
            w_main_ld_in = 1'b0;
          end
        end
        ST_ONE: begin
          // A simultaneous consume frees main, so the input replaces it directly.
          if (w_acc && w_con) begin
            w_main_ld_in = 1'b1;
          end else if (w_acc) begin
            w_skid_ld_in = 1'b1;
          end else begin
            w_main_ld_in = 1'b0;
          end
        end
        ST_TWO: begin
          if (w_con) begin
            w_main_ld_skid = 1'b1;
          end else begin
            w_main_ld_skid = 1'b0;
          end
        end
        default: begin
          w_clear = 1'b1;
        end
      endcase
    end
  end

  // Entry storage: main is the head, and skid is promoted when the head drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main <= {ENTRY_W{1'b0}};
      r_skid <= {ENTRY_W{1'b0}};
    end else if (w_clear) begin
      r_main <= {ENTRY_W{1'b0}};
      r_skid <= {ENTRY_W{1'b0}};
    end else begin
      if (w_main_ld_in) begin
        r_main <= w_in_entry;
      end else if (w_main_ld_skid) begin
        r_main <= r_skid;
      end else begin
        r_main <= r_main;
      end
      if (w_skid_ld_in) begin
        r_skid <= w_in_entry;
      end else begin
        r_skid <= r_skid;
      end
    end
  end

  // Writes to register 0 are optionally treated as no-ops.
  always_comb begin
    if (ZERO_REG_SUPPRESS != 0) begin
      w_dest_ok = (r_main.dest != {RADDR_W{1'b0}});
    end else begin
      w_dest_ok = 1'b1;
    end
  end

  // Write-back value select, taken straight from the head entry.
  always_comb begin
    if (r_main.wb[0]) begin
      WriteData = r_main.rdata;
    end else begin
      WriteData = r_main.alu;
    end
  end

  assign in_ready            = r_in_ready;
  assign out_valid           = r_out_valid;
  assign occupancy           = r_occupancy;
  assign RegWrite            = r_out_valid & r_main.wb[1] & w_dest_ok;
  assign MemtoReg            = r_main.wb[0];
  assign ReadData_out        = r_main.rdata;
  assign ALU_out             = r_main.alu;
  assign instruction_mux_out = r_main.dest;

endmodule

// File: doc/mem_wb_skid.md
MEM_WB_SKID -- requirements
Module: mem_wb_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the read-data, ALU-result and write-data paths.
REQ-002 SHALL have parameter RADDR_W, default 5, width of the destination-register field.
REQ-003 SHALL have parameter ZERO_REG_SUPPRESS, default 1; when 1, a write to register 0 is suppressed.
REQ-004 SHALL have clock and reset: one clock; reset is synchronous and active-high. Ports: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  upstream (MEM) entry valid.
REQ-006 in_ready  out  1  stage accepts an entry this cycle.
REQ-007 flush  in  1  discard all held entries and any input this cycle.
REQ-008 WB_in  in  2  bit1 RegWrite, bit0 MemtoReg.
REQ-009 ReadData_in  in  DATA_W  memory load data.
REQ-010 ALU_in  in  DATA_W  ALU result.
REQ-011 instruction_mux_in  in  RADDR_W  destination register.
REQ-012 out_ready  in  1  downstream (WB/register file) consumes the head entry.
REQ-013 out_valid  out  1  head entry valid.
REQ-014 RegWrite, MemtoReg  out  1 each  head-entry controls; RegWrite is gated per REQ-024.
REQ-015 ReadData_out, ALU_out  out  DATA_W each  head-entry data.
REQ-016 instruction_mux_out  out  RADDR_W  head-entry destination register.
REQ-017 WriteData  out  DATA_W  selected write-back value.
REQ-018 occupancy  out  2  number of held entries, 0..2.

Function
REQ-019 SHALL hold two entries: a main register (head) and a skid register; each entry is {WB, ReadData, ALU, dest}.
REQ-020 SHALL implement states EMPTY (occupancy 0), ONE (main full) and TWO (main and skid full).
REQ-021 in_ready SHALL be registered and SHALL equal 1 exactly when the state is not TWO; acc = in_valid & in_ready; con = out_valid & out_ready.
REQ-022 Transitions (no flush):
- EMPTY: acc -> ONE, main <= input.
- ONE: acc & con -> ONE, main <= input.
- ONE: acc & !con -> TWO, skid <= input.
- ONE: !acc & con -> EMPTY.
- ONE: neither -> hold.
- TWO: con -> ONE, main <= skid.
- TWO: !con -> hold.
REQ-023 out_valid SHALL be 1 in ONE and TWO; head outputs SHALL come from main; latency input->output is 1 cycle when EMPTY.
REQ-024 RegWrite SHALL be out_valid & main.WB[1] & (instruction_mux_out != 0 when ZERO_REG_SUPPRESS = 1, else 1).
REQ-025 WriteData SHALL be ReadData_out when MemtoReg = 1, else ALU_out (combinational from main).
REQ-026 Entries SHALL retain order; no entry SHALL be duplicated or dropped except by flush or reset.
REQ-027 flush SHALL move the state to EMPTY next cycle and discard the input presented that cycle even if acc = 1; a con in the same cycle still counts as consumed.
REQ-028 Held data SHALL not change while out_valid = 1 and out_ready = 0.
REQ-029 in_valid with in_ready = 0 SHALL have no effect; upstream holds its data.

Reset
REQ-030 On clk rising edge with reset = 1: state EMPTY, occupancy 0, in_ready 1, all data/control registers 0.
REQ-031 With reset asserted, out_valid, RegWrite, MemtoReg, ReadData_out, ALU_out, instruction_mux_out and WriteData SHALL read 0.
REQ-032 reset SHALL take priority over flush and all handshakes, including mid-operation in state TWO.

Verification
REQ-033 Reset, then in_valid = 1, WB_in = 2'b10, ALU_in = 0x0000_1234, dest = 5, out_ready = 1 -> next cycle out_valid = 1, RegWrite = 1, WriteData = 0x1234, instruction_mux_out = 5.
REQ-034 Push A (ALU 0xA) then B (ALU 0xB) with out_ready = 0 -> occupancy 2, in_ready = 0; raise out_ready -> WriteData 0xA then 0xB on consecutive cycles, then out_valid = 0.
REQ-035 WB_in = 2'b11, ReadData_in = 0xDEAD_BEEF, ALU_in = 0x4 -> WriteData = 0xDEAD_BEEF, MemtoReg = 1.
REQ-036 WB_in = 2'b10, dest = 0, ZERO_REG_SUPPRESS = 1 -> out_valid = 1, RegWrite = 0; with ZERO_REG_SUPPRESS = 0 -> RegWrite = 1.
REQ-037 State TWO, then flush = 1 together with in_valid = 1 -> next cycle occupancy 0, out_valid 0, in_ready 1; the flushed input never appears.
REQ-038 State TWO, then reset = 1 together with out_ready = 1 -> next cycle all outputs 0, occupancy 0.
